// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Optional bounds checking in dmem_lsu is enabled by defining DMEM_BOUNDS_CHECK_EN.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Reserved size is treated as always misaligned so it faults like any other bad access.
  function automatic logic misalign(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = lane[0];
      SZ_W:    misalign = |lane;
      default: misalign = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] size_be(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_B:    size_be = 4'b0001 << lane;
      SZ_H:    size_be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    size_be = 4'b1111;
      default: size_be = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enable word array with registered (synchronous) read; word 0 preloaded.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] INIT_WORD0  = 32'hdeadbeef,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic [3:0]             we,
  input  logic [AW-1:0]          idx,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem_q [DEPTH_WORDS] = '{0: INIT_WORD0, default: '0};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit over a single-cycle data memory with valid/ready request and response.
// Define DMEM_BOUNDS_CHECK_EN to fault on address bits above the array; otherwise they wrap.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] INIT_WORD0  = 32'hdeadbeef
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_addr_i,
  input  logic                   req_we_i,
  input  logic [1:0]             req_size_i,
  input  logic                   req_unsigned_i,
  input  logic [DMEM_DATA_W-1:0] req_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DMEM_DATA_W-1:0] rsp_rdata_o,
  output logic                   rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_e state_q, state_d;
  size_e  sz, sz_q;
  logic [1:0] lane, lane_q;
  logic [AW-1:0] idx, idx_q, bank_idx;
  logic uns_q, ld_q, err_q;
  logic oob, req_err, accept;
  logic [3:0] bank_we;
  logic [DMEM_DATA_W-1:0] bank_wdata, bank_rdata, sh, ext;

  assign sz      = size_e'(req_size_i);
  assign lane    = req_addr_i[1:0];
  assign idx     = req_addr_i[AW+1:2];
  assign oob     = BOUNDS_EN && (|req_addr_i[31:AW+2]);
  assign req_err = misalign(sz, lane) || oob;

  assign rsp_valid_o = (state_q == ST_RESP);
  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  // Gating on rst keeps a store that coincides with reset out of the array.
  assign accept      = req_valid_i && req_ready_o && !rst;

  assign bank_we  = (accept && req_we_i && !req_err) ? size_be(sz, lane) : 4'b0000;
  // Re-reading the held index keeps the response stable while stalled.
  assign bank_idx = accept ? idx : idx_q;

  always_comb begin
    bank_wdata = req_wdata_i;
    case (sz)
      SZ_B:    bank_wdata = {4{req_wdata_i[7:0]}};
      SZ_H:    bank_wdata = {2{req_wdata_i[15:0]}};
      default: bank_wdata = req_wdata_i;
    endcase
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_WORD0 (INIT_WORD0)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .idx  (bank_idx),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: if (accept) state_d = ST_RESP;
               else if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sz_q    <= SZ_W;
      lane_q  <= 2'b00;
      idx_q   <= '0;
      uns_q   <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sz_q   <= sz;
        lane_q <= lane;
        idx_q  <= idx;
        uns_q  <= req_unsigned_i;
        ld_q   <= !req_we_i && !req_err;
        err_q  <= req_err;
      end
    end
  end

  assign sh = bank_rdata >> {lane_q, 3'b000};

  always_comb begin
    ext = bank_rdata;
    case (sz_q)
      SZ_B:    ext = {{24{~uns_q & sh[7]}}, sh[7:0]};
      SZ_H:    ext = {{16{~uns_q & sh[15]}}, sh[15:0]};
      default: ext = bank_rdata;
    endcase
  end

  assign rsp_rdata_o = (rsp_valid_o && ld_q) ? ext : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu; the out-of-range case follows DMEM_BOUNDS_CHECK_EN.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;

  int checks   = 0;
  int failures = 0;

  dmem_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_we_i      (req_we_i),
    .req_size_i    (req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One request, response consumed immediately; checks latency, data and error.
  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd; rsp_ready_i = 1'b1;
    #1 chk({tag, ".rdy"}, 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk({tag, ".vld"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, ".d"},   rsp_rdata_o, exp_d);
    chk({tag, ".err"}, 32'(rsp_err_o), 32'(exp_e));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b10;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", 32'(rsp_valid_o), 32'd0);
    chk("rst.d",   rsp_rdata_o, 32'd0);
    chk("rst.err", 32'(rsp_err_o), 32'd0);
    rst = 1'b0;
    #1 chk("rst.rdy", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;

    xact("lw0",   1'b0, 2'b10, 1'b0, 32'h0,  32'h0,        32'hdeadbeef, 1'b0);
    xact("sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0);
    xact("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h00000011, 1'b0);
    xact("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h00001122, 1'b0);
    xact("lbu10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'h00000044, 1'b0);

    xact("sb21",  1'b1, 2'b00, 1'b0, 32'h21, 32'h80,       32'h0,        1'b0);
    xact("lw20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h00008000, 1'b0);
    xact("lb21",  1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'hffffff80, 1'b0);
    xact("lbu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        32'h00000080, 1'b0);

    xact("lw22e", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0,        32'h0,        1'b1);
    xact("sh23e", 1'b1, 2'b01, 1'b0, 32'h23, 32'hffff,     32'h0,        1'b1);
    xact("rsv20", 1'b1, 2'b11, 1'b0, 32'h20, 32'hffffffff, 32'h0,        1'b1);
    xact("lw20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h00008000, 1'b0);
    xact("lh20",  1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        32'hffff8000, 1'b0);
    xact("lhu22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h00000000, 1'b0);

    // Store then load of the same word on consecutive accepts.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h40; req_wdata_i = 32'hcafef00d; rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("b2b.st.vld", 32'(rsp_valid_o), 32'd1);
    chk("b2b.st.d",   rsp_rdata_o, 32'd0);
    req_we_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("b2b.ld.vld", 32'(rsp_valid_o), 32'd1);
    chk("b2b.ld.d",   rsp_rdata_o, 32'hcafef00d);
    @(posedge clk); #1;
    chk("b2b.idle", 32'(rsp_valid_o), 32'd0);

    // Backpressure: response held 3 cycles with a second request queued.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h10;
    rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    req_addr_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("stall.vld", 32'(rsp_valid_o), 32'd1);
      chk("stall.rdy", 32'(req_ready_o), 32'd0);
      chk("stall.d",   rsp_rdata_o, 32'h11223344);
      @(posedge clk); #1;
    end
    rsp_ready_i = 1'b1;
    #1 chk("stall.rdy1", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("stall.q.vld", 32'(rsp_valid_o), 32'd1);
    chk("stall.q.d",   rsp_rdata_o, 32'hdeadbeef);
    @(posedge clk); #1;
    chk("stall.idle", 32'(rsp_valid_o), 32'd0);

`ifdef DMEM_BOUNDS_CHECK_EN
    xact("lw1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0,        1'b1);
`else
    xact("lw1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'hdeadbeef, 1'b0);
`endif

    // Reset mid-response discards it; a store presented during reset is dropped.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h10;
    rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("mid.vld", 32'(rsp_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid.rst.vld", 32'(rsp_valid_o), 32'd0);
    chk("mid.rst.d",   rsp_rdata_o, 32'd0);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h30; req_wdata_i = 32'h12345678;
    @(posedge clk); #1;
    req_valid_i = 1'b0; rst = 1'b0; rsp_ready_i = 1'b1;
    chk("mid.post.vld", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    xact("lw30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, minimum 4.
REQ-002 SHALL have parameter INIT_WORD0, default 32'hdeadbeef, value preloaded into word 0 at elaboration.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port req_valid_i, input, 1 bit, request present.
REQ-006 SHALL have port req_ready_o, output, 1 bit, request accepted when it and req_valid_i are both high.
REQ-007 SHALL have port req_addr_i, input, 32 bits, byte address.
REQ-008 SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_size_i, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-010 SHALL have port req_unsigned_i, input, 1 bit, zero-extend loads.
REQ-011 SHALL have port req_wdata_i, input, 32 bits, store data, right-aligned.
REQ-012 SHALL have port rsp_valid_o, output, 1 bit, response present.
REQ-013 SHALL have port rsp_ready_i, input, 1 bit, response consumed.
REQ-014 SHALL have port rsp_rdata_o, output, 32 bits, extended load data.
REQ-015 SHALL have port rsp_err_o, output, 1 bit, access fault.

Function
REQ-016 SHALL be a two-state FSM: IDLE (no response held) and RESP (rsp_valid_o=1).
- IDLE to RESP on accept.
- RESP to IDLE on rsp_ready_i without a new accept.
- RESP stays in RESP on rsp_ready_i with a new accept.
REQ-017 SHALL drive req_ready_o = !rsp_valid_o || rsp_ready_i, combinationally; back-to-back throughput is 1 request per cycle.
REQ-018 SHALL present each response exactly one cycle after acceptance, with rsp_rdata_o and rsp_err_o held stable while rsp_valid_o && !rsp_ready_i.
REQ-019 SHALL decode the word index from req_addr_i[log2(DEPTH_WORDS)+1:2] and the byte lane from req_addr_i[1:0], little-endian.
REQ-020 SHALL commit stores on the accept edge, using byte enables only:
- SB: lane addr[1:0] gets wdata[7:0].
- SH: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
- SW: all four lanes get wdata.
REQ-021 SHALL read loads synchronously on the accept edge, shift the selected lane(s) to bit 0, then sign-extend or zero-extend per req_unsigned_i (ignored for word loads).
REQ-022 SHALL return rsp_rdata_o=0 and rsp_err_o=0 for a successful store.
REQ-023 SHALL set rsp_err_o=1, force rsp_rdata_o=0 and suppress any write when:
- a half access has addr[0]=1;
- a word access has addr[1:0]!=0;
- req_size_i=11.
REQ-024 SHALL make a load accepted in the cycle after a store to the same word return the new data; no forwarding path is needed.

Reset
REQ-025 SHALL, while rst is high, force:
- FSM state to IDLE;
- rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0;
- req_ready_o=1 once rst is released.
REQ-026 SHALL not reset the memory array; word 0 holds INIT_WORD0 only from elaboration.
REQ-027 SHALL discard a pending response when reset asserts mid-operation, and SHALL not write a store coincident with reset.

Configuration
REQ-028 SHALL use macro DMEM_BOUNDS_CHECK_EN.
- Defined: address bits above log2(DEPTH_WORDS)+1 that are nonzero raise rsp_err_o=1 with no write.
- Undefined: upper bits are ignored and addresses wrap modulo DEPTH_WORDS*4.

Structure
REQ-029 SHALL place in shared package dmem_pkg:
- size enum (SZ_B, SZ_H, SZ_W, SZ_RSV);
- FSM state enum;
- DMEM_DATA_W=32.
REQ-030 SHALL instantiate one sub-module dmem_bank: the byte-enable, synchronous-read array with ports clk, we[3:0], idx, wdata, rdata; all FSM, alignment and extension logic stays in dmem_lsu.

Verification
REQ-031 SHALL cover: after reset, LW addr 0x0 -> rsp_rdata_o=0xdeadbeef, rsp_err_o=0, one cycle after accept.
REQ-032 SHALL cover: SW 0x11223344 @0x10, then LB @0x13 -> 0x00000011; LH @0x12 -> 0x00001122; LBU @0x10 -> 0x00000044.
REQ-033 SHALL cover: SB 0x80 @0x21 over word 0 at 0x20 -> LW @0x20 = 0x00008000; LB @0x21 -> 0xffffff80; LBU @0x21 -> 0x00000080.
REQ-034 SHALL cover: LW @0x22, SH @0x23 and size=11 -> rsp_err_o=1 and rsp_rdata_o=0, with memory unchanged on readback.
REQ-035 SHALL cover: rsp_ready_i held low for 3 cycles with a new request queued -> req_ready_o=0 and response stable; the queued request is accepted on the cycle rsp_ready_i rises.
REQ-036 SHALL cover: DEPTH_WORDS=1024, LW @0x1000 -> rsp_err_o=1 with DMEM_BOUNDS_CHECK_EN defined; returns word 0 without it.
